pp_pipeline_accel_axi2mat_burst_planner: RTL and testbench

PP_PIPELINE_ACCEL_AXI2MAT_BURST_PLANNER -- requirements
Module: pp_pipeline_accel_axi2mat_burst_planner

---
 rtl/pp_pipeline_accel_pkg.sv | 18 +
 rtl/pp_pipeline_accel_start_chain.sv | 30 +++
 rtl/pp_pipeline_accel_axi2mat_burst_planner.sv | 142 ++++++++++++++
 tb/tb_pp_pipeline_accel_axi2mat_burst_planner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pipeline_accel_pkg.sv
// Shared types and constants for the pp_pipeline_accel entry processes.
package pp_pipeline_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DESC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Each descriptor carries {row_off, burst_rows}, both rows-width fields.
  localparam int DESC_FIELDS    = 2;
  localparam int SENTINEL_MAX_W = 64;

  // An all-ones stride marks a packed (contiguous) image; sliced to stride width at use.
  localparam logic [SENTINEL_MAX_W-1:0] PACKED_STRIDE = '1;

endpackage

// File: rtl/pp_pipeline_accel_start_chain.sv
// ap_ctrl_chain start forwarding: pushes one start token downstream per accepted start.
module pp_pipeline_accel_start_chain (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ap_start,
  input  logic i_start_full_n,
  input  logic i_ap_ready,
  output logic o_real_start,
  output logic o_start_write,
  output logic o_start_out
);

  logic r_start_once;

  // Once the token is pushed, a full start FIFO must not block the rest of this start.
  assign o_real_start  = (!i_start_full_n && !r_start_once) ? 1'b0 : i_ap_start;
  assign o_start_write = o_real_start & ~r_start_once;
  assign o_start_out   = o_real_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start_once <= 1'b0;
    end else if (i_ap_ready) begin
      r_start_once <= 1'b0;
    end else if (o_real_start) begin
      r_start_once <= 1'b1;
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_axi2mat_burst_planner.sv
// Forwards the row count to NUM_CH FIFOs, then plans read bursts as {row_off, burst_rows} descriptors.
module pp_pipeline_accel_axi2mat_burst_planner
  import pp_pipeline_accel_pkg::*;
#(
  parameter int ROWS_W    = 11,
  parameter int STRIDE_W  = 32,
  parameter int MAX_BURST = 16,
  parameter int NUM_CH    = 2
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          ap_start,
  input  logic                          ap_continue,
  input  logic                          start_full_n,
  output logic                          ap_done,
  output logic                          ap_idle,
  output logic                          ap_ready,
  output logic                          start_out,
  output logic                          start_write,
  input  logic [STRIDE_W-1:0]           stride,
  input  logic [ROWS_W-1:0]             rows,
  output logic [NUM_CH*ROWS_W-1:0]      rows_c_din,
  input  logic [NUM_CH-1:0]             rows_c_full_n,
  output logic [NUM_CH-1:0]             rows_c_write,
  output logic [DESC_FIELDS*ROWS_W-1:0] desc_din,
  input  logic                          desc_full_n,
  output logic                          desc_write,
  output logic [ROWS_W-1:0]             ap_return_0,
  output logic                          ap_return_1
);

  localparam logic [ROWS_W:0] BURST_STEP = (ROWS_W+1)'(MAX_BURST);

  state_t            r_state;
  logic [ROWS_W-1:0] r_rows;
  logic              r_packed;
  logic [ROWS_W:0]   r_off;
  logic [ROWS_W-1:0] r_cnt;
  logic [ROWS_W-1:0] r_ret0;
  logic              r_ret1;

  logic              w_real_start;
  logic              w_accept;
  logic              w_rows_wr;
  logic              w_desc_wr;
  logic              w_last;
  logic [ROWS_W:0]   w_remain;
  logic [ROWS_W:0]   w_step;
  logic [ROWS_W:0]   w_off_nxt;
  logic [ROWS_W-1:0] w_burst;

  pp_pipeline_accel_start_chain u_start_chain (
    .i_clk          (ap_clk),
    .i_rst_n        (ap_rst_n),
    .i_ap_start     (ap_start),
    .i_start_full_n (start_full_n),
    .i_ap_ready     (ap_ready),
    .o_real_start   (w_real_start),
    .o_start_write  (start_write),
    .o_start_out    (start_out)
  );

  assign w_accept  = (r_state == ST_IDLE) & w_real_start;
  // Strobes are gated by reset so an aborted frame emits nothing in the reset cycle.
  assign w_rows_wr = (r_state == ST_FWD) & (&rows_c_full_n) & ap_rst_n;
  assign w_desc_wr = (r_state == ST_DESC) & desc_full_n & ap_rst_n;

  // Offset math is one bit wider than rows so off+MAX_BURST cannot wrap.
  assign w_remain  = {1'b0, r_rows} - r_off;
  assign w_step    = r_packed ? BURST_STEP : (ROWS_W+1)'(1);
  assign w_off_nxt = r_off + w_step;
  assign w_last    = (w_off_nxt >= {1'b0, r_rows});
  assign w_burst   = !r_packed               ? ROWS_W'(1) :
                     (w_remain > BURST_STEP) ? ROWS_W'(MAX_BURST) :
                                               w_remain[ROWS_W-1:0];

  assign ap_ready     = w_accept & ap_rst_n;
  assign ap_idle      = (r_state == ST_IDLE) & ~w_real_start;
  assign ap_done      = (r_state == ST_DONE) & ap_rst_n;
  assign rows_c_din   = {NUM_CH{r_rows}};
  assign rows_c_write = {NUM_CH{w_rows_wr}};
  assign desc_din     = {r_off[ROWS_W-1:0], w_burst};
  assign desc_write   = w_desc_wr;
  assign ap_return_0  = r_ret0;
  assign ap_return_1  = r_ret1;

  always_ff @(posedge ap_clk) begin
    if (w_accept) begin
      r_rows   <= rows;
      r_packed <= (stride == PACKED_STRIDE[STRIDE_W-1:0]);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_off   <= '0;
      r_cnt   <= '0;
      r_ret0  <= '0;
      r_ret1  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_real_start) begin
            r_off   <= '0;
            r_cnt   <= '0;
            r_state <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (w_rows_wr) begin
            if (r_rows == '0) begin
              r_ret0  <= '0;
              r_ret1  <= r_packed;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DESC;
            end
          end
        end
        ST_DESC: begin
          if (w_desc_wr) begin
            r_off <= w_off_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_ret0  <= r_cnt + 1'b1;
              r_ret1  <= r_packed;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (ap_continue) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_axi2mat_burst_planner.sv
// Randomized self-checking bench for the burst planner against a queue-based descriptor model.
module tb_pp_pipeline_accel_axi2mat_burst_planner;

  localparam int ROWS_W    = 11;
  localparam int STRIDE_W  = 32;
  localparam int MAX_BURST = 16;
  localparam int NUM_CH    = 2;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic                     ap_start;
  logic                     ap_continue;
  logic                     start_full_n;
  logic                     ap_done;
  logic                     ap_idle;
  logic                     ap_ready;
  logic                     start_out;
  logic                     start_write;
  logic [STRIDE_W-1:0]      stride;
  logic [ROWS_W-1:0]        rows;
  logic [NUM_CH*ROWS_W-1:0] rows_c_din;
  logic [NUM_CH-1:0]        rows_c_full_n;
  logic [NUM_CH-1:0]        rows_c_write;
  logic [2*ROWS_W-1:0]      desc_din;
  logic                     desc_full_n;
  logic                     desc_write;
  logic [ROWS_W-1:0]        ap_return_0;
  logic                     ap_return_1;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_axi2mat_burst_planner #(
    .ROWS_W(ROWS_W), .STRIDE_W(STRIDE_W), .MAX_BURST(MAX_BURST), .NUM_CH(NUM_CH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .start_full_n(start_full_n), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .start_out(start_out), .start_write(start_write), .stride(stride), .rows(rows),
    .rows_c_din(rows_c_din), .rows_c_full_n(rows_c_full_n), .rows_c_write(rows_c_write),
    .desc_din(desc_din), .desc_full_n(desc_full_n), .desc_write(desc_write),
    .ap_return_0(ap_return_0), .ap_return_1(ap_return_1)
  );

  // bp: 0 none, 1 desc_full_n toggling, 2 random backpressure, 3 rows_c_full_n=01 for 5 cycles
  task automatic run_frame(input int nrows, input logic pk, input int bp, input string tag);
    logic [2*ROWS_W-1:0] exp_q[$];
    logic [2*ROWS_W-1:0] got_q[$];
    logic [STRIDE_W-1:0] s;
    int n_rows_wr = 0;
    int wr_cyc = -1;
    int done_cyc = -1;
    int b;
    s = pk ? '1 : STRIDE_W'($urandom_range(1, 4000));
    for (int off = 0; off < nrows; off += (pk ? MAX_BURST : 1)) begin
      b = pk ? (((nrows - off) < MAX_BURST) ? (nrows - off) : MAX_BURST) : 1;
      exp_q.push_back({ROWS_W'(off), ROWS_W'(b)});
    end

    @(negedge ap_clk);
    ap_start = 1'b1; rows = ROWS_W'(nrows); stride = s;
    rows_c_full_n = '1; desc_full_n = 1'b1; ap_continue = 1'b0; start_full_n = 1'b1;
    #1;
    checks++;
    if (ap_ready !== 1'b1 || start_write !== 1'b1 || ap_idle !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: ready=%b start_write=%b idle=%b required 1 1 0", tag, ap_ready, start_write, ap_idle);
    end

    for (int cyc = 0; cyc < 4000 && done_cyc < 0; cyc++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      rows = ROWS_W'($urandom);
      stride = $urandom;
      case (bp)
        1: begin rows_c_full_n = '1; desc_full_n = cyc[0]; end
        2: begin rows_c_full_n = NUM_CH'($urandom); desc_full_n = 1'($urandom); end
        3: begin rows_c_full_n = (cyc < 5) ? 2'b01 : 2'b11; desc_full_n = 1'b1; end
        default: begin rows_c_full_n = '1; desc_full_n = 1'b1; end
      endcase
      #1;
      if (rows_c_write !== '0) begin
        n_rows_wr++;
        wr_cyc = cyc;
        checks++;
        if (rows_c_write !== '1 || rows_c_full_n !== '1) begin
          errors++;
          $display("FAIL %s rows_c_write: write=%b full_n=%b required 11 with 11", tag, rows_c_write, rows_c_full_n);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
          checks++;
          if (rows_c_din[ch*ROWS_W +: ROWS_W] !== ROWS_W'(nrows)) begin
            errors++;
            $display("FAIL %s rows_c_din[%0d]: got %0d required %0d", tag, ch, rows_c_din[ch*ROWS_W +: ROWS_W], nrows);
          end
        end
      end
      if (desc_write === 1'b1) begin
        checks++;
        if (desc_full_n !== 1'b1 || n_rows_wr == 0) begin
          errors++;
          $display("FAIL %s desc_write: full_n=%b rows_writes=%0d required full_n=1 after rows write", tag, desc_full_n, n_rows_wr);
        end
        got_q.push_back(desc_din);
      end
      if (ap_done === 1'b1) done_cyc = cyc;
    end

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s timeout: ap_done never seen, required within 4000 cycles", tag);
    end
    checks++;
    if (n_rows_wr != 1) begin
      errors++;
      $display("FAIL %s rows_c writes: got %0d required 1", tag, n_rows_wr);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s descriptor count: got %0d required %0d", tag, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s desc[%0d]: got {%0d,%0d} required {%0d,%0d}", tag, i,
                   got_q[i][2*ROWS_W-1:ROWS_W], got_q[i][ROWS_W-1:0], exp_q[i][2*ROWS_W-1:ROWS_W], exp_q[i][ROWS_W-1:0]);
        end
      end
    end
    checks++;
    if (ap_return_0 !== ROWS_W'(exp_q.size()) || ap_return_1 !== pk) begin
      errors++;
      $display("FAIL %s ap_return: got %0d/%b required %0d/%b", tag, ap_return_0, ap_return_1, exp_q.size(), pk);
    end
    if (bp == 3) begin
      checks++;
      if (wr_cyc < 5) begin
        errors++;
        $display("FAIL %s stall: rows_c written at cycle %0d required >= 5", tag, wr_cyc);
      end
    end
    if (nrows == 0) begin
      checks++;
      if (done_cyc != wr_cyc + 1) begin
        errors++;
        $display("FAIL %s zero-rows done: done at %0d required %0d", tag, done_cyc, wr_cyc + 1);
      end
    end

    repeat (3) begin
      @(negedge ap_clk);
      #1;
      checks++;
      if (ap_done !== 1'b1 || desc_write !== 1'b0 || rows_c_write !== '0) begin
        errors++;
        $display("FAIL %s done hold: done=%b desc_write=%b rows_c_write=%b required 1 0 00", tag, ap_done, desc_write, rows_c_write);
      end
    end
    @(negedge ap_clk);
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("FAIL %s continue: idle=%b done=%b required 1 0", tag, ap_idle, ap_done);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; start_full_n = 1'b1;
    stride = '0; rows = '0; rows_c_full_n = '1; desc_full_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    checks++;
    if (ap_done !== 1'b0 || ap_ready !== 1'b0 || rows_c_write !== '0 || desc_write !== 1'b0 ||
        start_write !== 1'b0 || ap_return_0 !== '0 || ap_return_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: done=%b ready=%b rcw=%b dw=%b sw=%b ret=%0d/%b required all zero",
               ap_done, ap_ready, rows_c_write, desc_write, start_write, ap_return_0, ap_return_1);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset idle: got %b required 1", ap_idle);
    end
  endtask

  task automatic test_start_chain();
    @(negedge ap_clk);
    ap_start = 1'b1; start_full_n = 1'b0; rows = '0; stride = 32'd7; rows_c_full_n = '1;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || start_write !== 1'b0 || start_out !== 1'b0) begin
      errors++;
      $display("FAIL start blocked: idle=%b ready=%b sw=%b so=%b required 1 0 0 0", ap_idle, ap_ready, start_write, start_out);
    end
    @(negedge ap_clk);
    start_full_n = 1'b1;
    #1;
    checks++;
    if (ap_ready !== 1'b1 || start_write !== 1'b1 || start_out !== 1'b1) begin
      errors++;
      $display("FAIL start accept: ready=%b sw=%b so=%b required 1 1 1", ap_ready, start_write, start_out);
    end
    @(negedge ap_clk);
    @(negedge ap_clk);
    start_full_n = 1'b0;
    #1;
    checks++;
    if (start_write !== 1'b0 || start_out !== 1'b1 || ap_done !== 1'b1) begin
      errors++;
      $display("FAIL start once: sw=%b so=%b done=%b required 0 1 1", start_write, start_out, ap_done);
    end
    ap_start = 1'b0; start_full_n = 1'b1;
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_desc();
    int nd = 0;
    @(negedge ap_clk);
    ap_start = 1'b1; rows = ROWS_W'(100); stride = '1; rows_c_full_n = '1; desc_full_n = 1'b1;
    for (int cyc = 0; cyc < 50 && nd < 2; cyc++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
      #1;
      if (desc_write === 1'b1) nd++;
    end
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL mid reset setup: descriptors seen %0d required 2", nd);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (desc_write !== 1'b0 || rows_c_write !== '0 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid reset strobes: dw=%b rcw=%b done=%b ready=%b required 0", desc_write, rows_c_write, ap_done, ap_ready);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || desc_write !== 1'b0 || ap_return_0 !== '0 || ap_return_1 !== 1'b0) begin
      errors++;
      $display("FAIL mid reset state: idle=%b dw=%b ret=%0d/%b required 1 0 0/0", ap_idle, desc_write, ap_return_0, ap_return_1);
    end
    run_frame(40, 1'b1, 0, "restart");
  endtask

  task automatic test_packed();      run_frame(40, 1'b1, 0, "packed40");   endtask
  task automatic test_unpacked();    run_frame(3, 1'b0, 0, "unpacked3");   endtask
  task automatic test_rows_zero();   run_frame(0, 1'b1, 0, "rows0");       endtask
  task automatic test_rows_stall();  run_frame(20, 1'b1, 3, "rows_stall"); endtask
  task automatic test_desc_toggle(); run_frame(37, 1'b0, 1, "desc_toggle"); run_frame(50, 1'b1, 1, "desc_toggle_pk"); endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(0, 120)), 1'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_packed();
    test_unpacked();
    test_rows_zero();
    test_rows_stall();
    test_desc_toggle();
    test_start_chain();
    test_reset_mid_desc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
